// File: rtl/sound_pkg.sv
// Shared constants, state type and note/length tables for the game sound sequencer.
// SEQ_GAP_EN adds a silent GAP state between notes.
package sound_pkg;

  localparam int unsigned SND_SEQ_W = 2;
  localparam int unsigned SND_IDX_W = 3;
  localparam int unsigned SND_LEN_W = 4;
  localparam int unsigned SND_CNT_W = 32;

  localparam int unsigned SEQ_APPLE = 0;
  localparam int unsigned SEQ_OVER  = 1;
  localparam int unsigned SEQ_WIN   = 2;
  localparam int unsigned SEQ_TICK  = 3;

`ifdef SEQ_GAP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1
  } state_t;
`endif

  // Number of note slots per sequence.
  function automatic logic [SND_LEN_W-1:0] seq_len(input logic [SND_SEQ_W-1:0] seq);
    logic [SND_LEN_W-1:0] r;
    r = SND_LEN_W'(1);
    case (seq)
      SND_SEQ_W'(SEQ_APPLE): r = SND_LEN_W'(3);
      SND_SEQ_W'(SEQ_OVER):  r = SND_LEN_W'(8);
      SND_SEQ_W'(SEQ_WIN):   r = SND_LEN_W'(5);
      SND_SEQ_W'(SEQ_TICK):  r = SND_LEN_W'(1);
      default:               r = SND_LEN_W'(1);
    endcase
    return r;
  endfunction

  // Divider terminal count per (sequence, slot); 0 is a rest.
  function automatic logic [SND_CNT_W-1:0] note_count(input logic [SND_SEQ_W-1:0] seq,
                                                      input logic [SND_IDX_W-1:0] idx);
    logic [SND_CNT_W-1:0] r;
    r = '0;
    case (seq)
      SND_SEQ_W'(SEQ_APPLE): begin
        case (idx)
          SND_IDX_W'(0): r = SND_CNT_W'(20);
          SND_IDX_W'(1): r = SND_CNT_W'(10);
          SND_IDX_W'(2): r = SND_CNT_W'(1500000);
          default:       r = '0;
        endcase
      end
      SND_SEQ_W'(SEQ_OVER): begin
        case (idx)
          SND_IDX_W'(0): r = SND_CNT_W'(20);
          SND_IDX_W'(1): r = SND_CNT_W'(10);
          SND_IDX_W'(2): r = SND_CNT_W'(30);
          SND_IDX_W'(3): r = SND_CNT_W'(40);
          default:       r = SND_CNT_W'(50);
        endcase
      end
      SND_SEQ_W'(SEQ_WIN): begin
        case (idx)
          SND_IDX_W'(0): r = SND_CNT_W'(10);
          SND_IDX_W'(1): r = '0;
          SND_IDX_W'(2): r = SND_CNT_W'(10);
          SND_IDX_W'(3): r = '0;
          SND_IDX_W'(4): r = SND_CNT_W'(5);
          default:       r = '0;
        endcase
      end
      SND_SEQ_W'(SEQ_TICK): begin
        r = (idx == '0) ? SND_CNT_W'(40) : '0;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Request/ack handshake plus note outputs between the game requesters and the sequencer.
interface sound_sequencer_if #(
  parameter int unsigned NUM_SEQ = 4,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned CNT_W   = 32
);
  logic [NUM_SEQ-1:0] req;
  logic [NUM_SEQ-1:0] ack;
  logic [CNT_W-1:0]   freq_count;
  logic               play;
  logic               busy;
  logic [1:0]         active_seq;
  logic [IDX_W-1:0]   note_idx;
  logic               done;

  modport master (
    output req,
    input  ack, freq_count, play, busy, active_seq, note_idx, done
  );

  modport slave (
    input  req,
    output ack, freq_count, play, busy, active_seq, note_idx, done
  );
endinterface

// File: rtl/sound_note_rom.sv
// Combinational lookup of a sequence's note count and its length from the package tables.
module sound_note_rom
  import sound_pkg::*;
(
  input  logic [SND_SEQ_W-1:0] seq,
  input  logic [SND_IDX_W-1:0] idx,
  output logic [SND_CNT_W-1:0] count_c,
  output logic [SND_LEN_W-1:0] len_c
);

  always_comb begin
    count_c = note_count(seq, idx);
    len_c   = seq_len(seq);
  end

endmodule

// File: rtl/sound_sequencer.sv
// Priority-arbitrated multi-channel note sequencer clocked by the note-duration tick.
// Define SEQ_GAP_EN to insert a silent one-slot GAP after every note except the last.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned NUM_SEQ = 4,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic durationClk,
  input  logic rst,
  sound_sequencer_if.slave bus
);

  state_t               state_q, state_d;
  logic [NUM_SEQ-1:0]   ack_q, ack_d;
  logic [CNT_W-1:0]     freq_q, freq_d;
  logic                 play_q, play_d;
  logic                 busy_q, busy_d;
  logic [SND_SEQ_W-1:0] seq_q, seq_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SND_LEN_W-1:0] len_q, len_d;
  logic                 done_q, done_d;

  logic [NUM_SEQ-1:0]   elig_c;
  logic                 hi_valid_c;
  logic [SND_SEQ_W-1:0] hi_idx_c;
  logic                 start_c;
  logic                 last_c;
  logic [SND_SEQ_W-1:0] ld_seq_c;
  logic [IDX_W-1:0]     ld_idx_c;
  logic [SND_CNT_W-1:0] rom_count_c;
  logic [SND_LEN_W-1:0] rom_len_c;

  // Highest pending request wins; a channel acked last cycle is masked so ack never repeats back-to-back.
  always_comb begin : pick
    elig_c     = bus.req & ~ack_q;
    hi_valid_c = 1'b0;
    hi_idx_c   = '0;
    for (int i = 0; i < int'(NUM_SEQ); i++) begin
      if (elig_c[i]) begin
        hi_valid_c = 1'b1;
        hi_idx_c   = SND_SEQ_W'(i);
      end
    end
    start_c  = hi_valid_c && ((state_q == IDLE) || (hi_idx_c >= seq_q));
    ld_seq_c = start_c ? hi_idx_c : seq_q;
    ld_idx_c = start_c ? '0 : idx_q + IDX_W'(1);
  end

  sound_note_rom u_rom (
    .seq     (ld_seq_c),
    .idx     (SND_IDX_W'(ld_idx_c)),
    .count_c (rom_count_c),
    .len_c   (rom_len_c)
  );

  always_comb begin : next
    state_d = state_q;
    ack_d   = '0;
    freq_d  = freq_q;
    play_d  = play_q;
    busy_d  = busy_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    last_c  = (SND_LEN_W'(idx_q) == (len_q - SND_LEN_W'(1)));

    if (start_c) begin
      // New start, preemption and retrigger all restart at note 0.
      state_d = PLAY;
      ack_d   = NUM_SEQ'(1) << hi_idx_c;
      seq_d   = hi_idx_c;
      idx_d   = '0;
      len_d   = rom_len_c;
      freq_d  = CNT_W'(rom_count_c);
      play_d  = (rom_count_c != '0);
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (last_c) begin
            state_d = IDLE;
            freq_d  = '0;
            play_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
`ifdef SEQ_GAP_EN
            state_d = GAP;
            play_d  = 1'b0;
`else
            idx_d   = ld_idx_c;
            freq_d  = CNT_W'(rom_count_c);
            play_d  = (rom_count_c != '0);
`endif
          end
        end
`ifdef SEQ_GAP_EN
        GAP: begin
          state_d = PLAY;
          idx_d   = ld_idx_c;
          freq_d  = CNT_W'(rom_count_c);
          play_d  = (rom_count_c != '0);
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge durationClk) begin : regs
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      freq_q  <= '0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
      seq_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      freq_q  <= freq_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.freq_count = freq_q;
  assign bus.play       = play_q;
  assign bus.busy       = busy_q;
  assign bus.active_seq = seq_q;
  assign bus.note_idx   = idx_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed self-checking bench for sound_sequencer; build with SEQ_GAP_EN to exercise the GAP variant.
module tb_sound_sequencer;

  logic durationClk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  sound_sequencer_if #(.NUM_SEQ(4), .IDX_W(3), .CNT_W(32)) bus ();

  sound_sequencer #(.NUM_SEQ(4), .IDX_W(3), .CNT_W(32)) dut (
    .durationClk (durationClk),
    .rst         (rst),
    .bus         (bus)
  );

  always #5 durationClk = ~durationClk;

  int unsigned exp_note [4][8] = '{
    '{20, 10, 1500000, 0, 0, 0, 0, 0},
    '{20, 10, 30, 40, 50, 50, 50, 50},
    '{10, 0, 10, 0, 5, 0, 0, 0},
    '{40, 0, 0, 0, 0, 0, 0, 0}
  };

  task automatic tick();
    @(posedge durationClk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 4'b0001;
    tick();
    tick();
    total++;
    if ({bus.ack, bus.play, bus.busy, bus.active_seq, bus.note_idx, bus.done} !== 12'd0 ||
        bus.freq_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got ack=%b freq=%0d play=%b busy=%b seq=%0d idx=%0d done=%b want all 0",
               bus.ack, bus.freq_count, bus.play, bus.busy, bus.active_seq, bus.note_idx, bus.done);
    end
  endtask

  task automatic test_apple();
    rst = 1'b1;
    tick();
    total++;
    if (bus.ack !== 4'b0001 || bus.freq_count !== 32'd20 || bus.play !== 1'b1 ||
        bus.busy !== 1'b1 || bus.active_seq !== 2'd0 || bus.note_idx !== 3'd0) begin
      bad++;
      $display("FAIL apple_start got ack=%b freq=%0d play=%b busy=%b want ack=0001 freq=20 play=1 busy=1",
               bus.ack, bus.freq_count, bus.play, bus.busy);
    end
    bus.req = 4'b0000;
    for (int k = 1; k < 3; k++) begin
      tick();
      total++;
      if (bus.freq_count !== exp_note[0][k] || bus.note_idx !== 3'(k) || bus.ack !== 4'b0000 ||
          bus.done !== 1'b0) begin
        bad++;
        $display("FAIL apple_note%0d got freq=%0d idx=%0d ack=%b want freq=%0d idx=%0d ack=0000",
                 k, bus.freq_count, bus.note_idx, bus.ack, exp_note[0][k], k);
      end
    end
    tick();
    total++;
    if (bus.done !== 1'b1 || bus.play !== 1'b0 || bus.busy !== 1'b0 || bus.freq_count !== 32'd0) begin
      bad++;
      $display("FAIL apple_end got done=%b play=%b busy=%b freq=%0d want 1 0 0 0",
               bus.done, bus.play, bus.busy, bus.freq_count);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL apple_done_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_over();
    bus.req = 4'b0010;
    tick();
    total++;
    if (bus.ack !== 4'b0010 || bus.freq_count !== 32'd20 || bus.active_seq !== 2'd1 ||
        bus.note_idx !== 3'd0) begin
      bad++;
      $display("FAIL over_start got ack=%b freq=%0d seq=%0d idx=%0d want 0010 20 1 0",
               bus.ack, bus.freq_count, bus.active_seq, bus.note_idx);
    end
    bus.req = 4'b0000;
    for (int k = 1; k < 8; k++) begin
      tick();
      total++;
      if (bus.freq_count !== exp_note[1][k] || bus.note_idx !== 3'(k) || bus.play !== 1'b1 ||
          bus.done !== 1'b0) begin
        bad++;
        $display("FAIL over_note%0d got freq=%0d idx=%0d play=%b done=%b want freq=%0d idx=%0d play=1 done=0",
                 k, bus.freq_count, bus.note_idx, bus.play, bus.done, exp_note[1][k], k);
      end
    end
    tick();
    total++;
    if (bus.done !== 1'b1 || bus.note_idx !== 3'd7 || bus.busy !== 1'b0 || bus.play !== 1'b0) begin
      bad++;
      $display("FAIL over_end got done=%b idx=%0d busy=%b play=%b want 1 7 0 0",
               bus.done, bus.note_idx, bus.busy, bus.play);
    end
    tick();
  endtask

  task automatic test_preempt();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    total++;
    if (bus.freq_count !== 32'd10 || bus.note_idx !== 3'd1) begin
      bad++;
      $display("FAIL preempt_pre got freq=%0d idx=%0d want 10 1", bus.freq_count, bus.note_idx);
    end
    bus.req = 4'b0010;
    tick();
    total++;
    if (bus.ack !== 4'b0010 || bus.freq_count !== 32'd20 || bus.active_seq !== 2'd1 ||
        bus.note_idx !== 3'd0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL preempt_load got ack=%b freq=%0d seq=%0d idx=%0d done=%b want 0010 20 1 0 0",
               bus.ack, bus.freq_count, bus.active_seq, bus.note_idx, bus.done);
    end
    bus.req = 4'b0000;
    for (int k = 1; k < 8; k++) begin
      tick();
      total++;
      if (bus.done !== 1'b0 || bus.note_idx !== 3'(k)) begin
        bad++;
        $display("FAIL preempt_run%0d got done=%b idx=%0d want 0 %0d", k, bus.done, bus.note_idx, k);
      end
    end
    tick();
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL preempt_done got %b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_low_pending();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0001;
    for (int k = 1; k < 8; k++) begin
      tick();
      total++;
      if (bus.ack !== 4'b0000 || bus.active_seq !== 2'd1 || bus.note_idx !== 3'(k)) begin
        bad++;
        $display("FAIL low_wait%0d got ack=%b seq=%0d idx=%0d want 0000 1 %0d",
                 k, bus.ack, bus.active_seq, bus.note_idx, k);
      end
    end
    tick();
    total++;
    if (bus.done !== 1'b1 || bus.ack !== 4'b0000) begin
      bad++;
      $display("FAIL low_done got done=%b ack=%b want 1 0000", bus.done, bus.ack);
    end
    tick();
    total++;
    if (bus.ack !== 4'b0001 || bus.active_seq !== 2'd0 || bus.freq_count !== 32'd20 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL low_start got ack=%b seq=%0d freq=%0d busy=%b want 0001 0 20 1",
               bus.ack, bus.active_seq, bus.freq_count, bus.busy);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL low_end got done=%b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_win_simul();
    logic exp_play [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.req = 4'b1100;
    tick();
    total++;
    if (bus.ack !== 4'b1000 || bus.active_seq !== 2'd3 || bus.freq_count !== 32'd40 || bus.play !== 1'b1) begin
      bad++;
      $display("FAIL simul_first got ack=%b seq=%0d freq=%0d play=%b want 1000 3 40 1",
               bus.ack, bus.active_seq, bus.freq_count, bus.play);
    end
    bus.req = 4'b0100;
    tick();
    total++;
    if (bus.done !== 1'b1 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL tick_done got done=%b ack=%b busy=%b want 1 0000 0", bus.done, bus.ack, bus.busy);
    end
    tick();
    total++;
    if (bus.ack !== 4'b0100 || bus.active_seq !== 2'd2 || bus.freq_count !== 32'd10 || bus.play !== 1'b1) begin
      bad++;
      $display("FAIL win_start got ack=%b seq=%0d freq=%0d play=%b want 0100 2 10 1",
               bus.ack, bus.active_seq, bus.freq_count, bus.play);
    end
    bus.req = 4'b0000;
    for (int k = 1; k < 5; k++) begin
      tick();
      total++;
      if (bus.freq_count !== exp_note[2][k] || bus.play !== exp_play[k] || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL win_note%0d got freq=%0d play=%b busy=%b want freq=%0d play=%b busy=1",
                 k, bus.freq_count, bus.play, bus.busy, exp_note[2][k], exp_play[k]);
      end
    end
    tick();
    total++;
    if (bus.done !== 1'b1 || bus.play !== 1'b0) begin
      bad++;
      $display("FAIL win_end got done=%b play=%b want 1 0", bus.done, bus.play);
    end
    tick();
  endtask

  task automatic test_retrigger();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0001;
    tick();
    total++;
    if (bus.ack !== 4'b0001 || bus.note_idx !== 3'd0 || bus.freq_count !== 32'd20 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL retrigger got ack=%b idx=%0d freq=%0d done=%b want 0001 0 20 0",
               bus.ack, bus.note_idx, bus.freq_count, bus.done);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL retrigger_end got done=%b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (bus.note_idx !== 3'd4 || bus.freq_count !== 32'd50) begin
      bad++;
      $display("FAIL mid_pre got idx=%0d freq=%0d want 4 50", bus.note_idx, bus.freq_count);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({bus.ack, bus.play, bus.busy, bus.active_seq, bus.note_idx, bus.done} !== 12'd0 ||
          bus.freq_count !== 32'd0) begin
        bad++;
        $display("FAIL mid_reset%0d got ack=%b freq=%0d busy=%b idx=%0d done=%b want all 0",
                 k, bus.ack, bus.freq_count, bus.busy, bus.note_idx, bus.done);
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_release got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_gap();
    int unsigned exp_f [5] = '{20, 20, 10, 10, 1500000};
    logic        exp_p [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  exp_i [5] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) bus.req = 4'b0000;
      total++;
      if (bus.freq_count !== exp_f[k] || bus.play !== exp_p[k] || bus.note_idx !== exp_i[k] ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL gap_slot%0d got freq=%0d play=%b idx=%0d busy=%b want freq=%0d play=%b idx=%0d busy=1",
                 k, bus.freq_count, bus.play, bus.note_idx, bus.busy, exp_f[k], exp_p[k], exp_i[k]);
      end
    end
    tick();
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL gap_end got done=%b busy=%b want 1 0", bus.done, bus.busy);
    end
    tick();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0100;
    tick();
    total++;
    if (bus.ack !== 4'b0100 || bus.active_seq !== 2'd2 || bus.freq_count !== 32'd10 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL gap_preempt got ack=%b seq=%0d freq=%0d done=%b want 0100 2 10 0",
               bus.ack, bus.active_seq, bus.freq_count, bus.done);
    end
    bus.req = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
    tick();
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL gap_win_end got done=%b want 1", bus.done);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.req = 4'b0000;
    test_reset();
`ifdef SEQ_GAP_EN
    test_gap();
`else
    test_apple();
    test_over();
    test_preempt();
    test_low_pending();
    test_win_simul();
    test_retrigger();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
